// File: rtl/pw_bit_cell.sv
// pw_bit_cell: pulse-width bit encoder.
//
// Takes words from an AXI4-Stream slave and sends each one MSB-first on txd.
// Every bit gets a slot of P clocks. The line is high for duty_hi clocks when
// the bit is 1 and for duty_lo clocks when it is 0, then low for the rest of
// the slot. After a word marked tlast the line stays low for one more P-clock
// gap before the next word is accepted.
//
// Ports
//   aclk, aresetn        clock; asynchronous active-low reset
//   txd                  encoded serial output (registered)
//   data_s_axis_*        word stream in (tdata, tlast, tvalid, tready)
//   period               slot length in clocks (0 is treated as 1)
//   duty_hi, duty_lo     high time of a 1 / 0 bit
//
// The configuration is captured on every accepted beat. Only its low
// COUNTER_WIDTH bits are used.
//
// state | meaning
// IDLE  | waiting for a beat, tready high
// BIT   | sending a word; cnt is the position in the slot, idx is the bit index
// GAP   | P low clocks after a tlast word
module pw_bit_cell #(
  parameter int COUNTER_WIDTH        = 32,
  parameter int DATA_AXIS_DATA_WIDTH = 8,
  parameter int CFG_AXIS_DATA_WIDTH  = COUNTER_WIDTH*2
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  output logic                            txd,
  input  logic [DATA_AXIS_DATA_WIDTH-1:0] data_s_axis_tdata,
  input  logic                            data_s_axis_tlast,
  input  logic                            data_s_axis_tvalid,
  output logic                            data_s_axis_tready,
  input  logic [CFG_AXIS_DATA_WIDTH-1:0]  period,
  input  logic [CFG_AXIS_DATA_WIDTH-1:0]  duty_hi,
  input  logic [CFG_AXIS_DATA_WIDTH-1:0]  duty_lo
);

  localparam int CW = COUNTER_WIDTH;
  localparam int DW = DATA_AXIS_DATA_WIDTH;
  localparam int IW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [IW-1:0] IDX_MSB = IW'(DW-1);
  localparam logic [CW-1:0] ONE     = CW'(1);

  typedef enum logic [1:0] {IDLE, BIT, GAP} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [IW-1:0]   idx, idx_n;
  logic [DW-1:0]   word, word_n;
  logic            word_last, word_last_n;
  logic [CW-1:0]   per, per_n;
  logic [CW-1:0]   dhi, dhi_n;
  logic [CW-1:0]   dlo, dlo_n;
  logic            txd_n, tready_n;

  logic [CW-1:0]   period_in, duty_hi_in, duty_lo_in, period_eff;
  logic [CW-1:0]   duty_cur;
  logic            accept, slot_end;

  // Bring the configuration inputs to counter width.
  generate
    if (CFG_AXIS_DATA_WIDTH >= CW) begin : g_cfg_trunc
      assign period_in  = period[CW-1:0];
      assign duty_hi_in = duty_hi[CW-1:0];
      assign duty_lo_in = duty_lo[CW-1:0];
      if (CFG_AXIS_DATA_WIDTH > CW) begin : g_cfg_unused
        logic unused_cfg_hi;
        assign unused_cfg_hi = ^{period[CFG_AXIS_DATA_WIDTH-1:CW],
                                 duty_hi[CFG_AXIS_DATA_WIDTH-1:CW],
                                 duty_lo[CFG_AXIS_DATA_WIDTH-1:CW]};
      end
    end else begin : g_cfg_ext
      assign period_in  = {{(CW-CFG_AXIS_DATA_WIDTH){1'b0}}, period};
      assign duty_hi_in = {{(CW-CFG_AXIS_DATA_WIDTH){1'b0}}, duty_hi};
      assign duty_lo_in = {{(CW-CFG_AXIS_DATA_WIDTH){1'b0}}, duty_lo};
    end
  endgenerate

  assign period_eff = (period_in == '0) ? ONE : period_in;
  assign accept     = data_s_axis_tvalid && data_s_axis_tready;
  assign duty_cur   = word[idx] ? dhi : dlo;
  assign slot_end   = (cnt == per - ONE);

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    idx_n       = idx;
    word_n      = word;
    word_last_n = word_last;
    per_n       = per;
    dhi_n       = dhi;
    dlo_n       = dlo;

    // txd is registered, so the value for slot position cnt shows on the
    // following edge. This places slot k at E0+1+k*P .. E0+(k+1)*P.
    txd_n = (state == BIT) && (cnt < duty_cur);

    case (state)
      BIT: begin
        if (slot_end) begin
          cnt_n = '0;
          if (idx != '0)
            idx_n = idx - IW'(1);
          else if (word_last)
            state_n = GAP;
          else
            state_n = IDLE;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      GAP: begin
        if (slot_end) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      default: ;
    endcase

    // Acceptance can only happen in IDLE or in the final cycle of a
    // non-tlast word. In that final cycle it overrides the return to IDLE.
    if (accept) begin
      state_n     = BIT;
      cnt_n       = '0;
      idx_n       = IDX_MSB;
      word_n      = data_s_axis_tdata;
      word_last_n = data_s_axis_tlast;
      per_n       = period_eff;
      dhi_n       = duty_hi_in;
      dlo_n       = duty_lo_in;
    end

    // tready is registered. It is computed from the next state so that it is
    // high exactly during the last cycle of the last slot of a non-tlast word.
    tready_n = (state_n == IDLE) ||
               ((state_n == BIT) && (idx_n == '0) &&
                (cnt_n == per_n - ONE) && !word_last_n);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state              <= IDLE;
      cnt                <= '0;
      idx                <= '0;
      word               <= '0;
      word_last          <= 1'b0;
      per                <= '0;
      dhi                <= '0;
      dlo                <= '0;
      txd                <= 1'b0;
      data_s_axis_tready <= 1'b0;
    end else begin
      state              <= state_n;
      cnt                <= cnt_n;
      idx                <= idx_n;
      word               <= word_n;
      word_last          <= word_last_n;
      per                <= per_n;
      dhi                <= dhi_n;
      dlo                <= dlo_n;
      txd                <= txd_n;
      data_s_axis_tready <= tready_n;
    end
  end

endmodule

// File: tb/tb_pw_bit_cell.sv
// Testbench for pw_bit_cell (COUNTER_WIDTH=8, 8-bit data and config).
// The reference model builds the expected txd/tready waveform directly from
// the slot arithmetic: word i is accepted at edge a_i, and slot k of that word
// covers edges a_i+1+k*P .. a_i+(k+1)*P.
`timescale 1ns/1ps
module tb_pw_bit_cell;

  localparam int CW   = 8;
  localparam int DW   = 8;
  localparam int CFW  = 8;
  localparam int MAXC = 2048;
  localparam int MAXW = 8;

  logic           aclk = 1'b0;
  logic           aresetn = 1'b0;
  logic           txd;
  logic [DW-1:0]  tdata = '0;
  logic           tlast = 1'b0;
  logic           tvalid = 1'b0;
  logic           tready;
  logic [CFW-1:0] period = '0;
  logic [CFW-1:0] duty_hi = '0;
  logic [CFW-1:0] duty_lo = '0;

  int checks = 0;
  int failures = 0;
  int acc_cnt = 0;
  int run_acc;

  int n_words;
  int w_data[MAXW];
  int w_last[MAXW];
  int w_per[MAXW];
  int w_dhi[MAXW];
  int w_dlo[MAXW];

  bit   exp_txd[MAXC];
  bit   exp_rdy[MAXC];
  logic obs_txd[MAXC];
  logic obs_rdy[MAXC];
  int   n_cyc;

  pw_bit_cell #(
    .COUNTER_WIDTH(CW),
    .DATA_AXIS_DATA_WIDTH(DW),
    .CFG_AXIS_DATA_WIDTH(CFW)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .txd(txd),
    .data_s_axis_tdata(tdata),
    .data_s_axis_tlast(tlast),
    .data_s_axis_tvalid(tvalid),
    .data_s_axis_tready(tready),
    .period(period),
    .duty_hi(duty_hi),
    .duty_lo(duty_lo)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk)
    if (aresetn && tvalid && tready) acc_cnt <= acc_cnt + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int eff(input int p);
    return (p == 0) ? 1 : p;
  endfunction

  task automatic drive(input int i);
    tdata   = DW'(w_data[i]);
    tlast   = w_last[i][0];
    period  = CFW'(w_per[i]);
    duty_hi = CFW'(w_dhi[i]);
    duty_lo = CFW'(w_dlo[i]);
  endtask

  // Presents the word list with tvalid held, starting from idle, and records
  // txd/tready after every edge. The expected waveform is built at the same time.
  task automatic run_frame();
    int acc[MAXW];
    int t;
    int p;
    int t_end;
    int nxt;
    int acc_base;
    t = 0;
    for (int i = 0; i < n_words; i++) begin
      acc[i] = t;
      p = eff(w_per[i]);
      t = w_last[i] ? t + (DW+1)*p + 1 : t + DW*p;
    end
    p = eff(w_per[n_words-1]);
    t_end = acc[n_words-1] + (w_last[n_words-1] ? (DW+1)*p : DW*p) + 3;
    for (int c = 0; c <= t_end; c++) begin
      exp_txd[c] = 1'b0;
      exp_rdy[c] = 1'b0;
    end
    for (int i = 0; i < n_words; i++) begin
      p = eff(w_per[i]);
      for (int s = 1; s <= DW*p; s++) begin
        int k, c, b, d;
        k = (s-1) / p;
        c = (s-1) % p;
        b = (w_data[i] >> (DW-1-k)) & 1;
        d = (b != 0) ? w_dhi[i] : w_dlo[i];
        exp_txd[acc[i]+s] = (c < d);
      end
      if (w_last[i] == 0) begin
        if (i == n_words-1)
          for (int c = acc[i]+DW*p-1; c <= t_end; c++) exp_rdy[c] = 1'b1;
        else
          exp_rdy[acc[i]+DW*p-1] = 1'b1;
      end else begin
        if (i == n_words-1)
          for (int c = acc[i]+(DW+1)*p; c <= t_end; c++) exp_rdy[c] = 1'b1;
        else
          exp_rdy[acc[i]+(DW+1)*p] = 1'b1;
      end
    end
    n_cyc = t_end + 1;
    acc_base = acc_cnt;
    drive(0);
    tvalid = 1'b1;
    nxt = 1;
    for (int tt = 0; tt <= t_end; tt++) begin
      @(posedge aclk);
      #1;
      obs_txd[tt] = txd;
      obs_rdy[tt] = tready;
      if (nxt <= n_words && tt == acc[nxt-1]) begin
        if (nxt < n_words) drive(nxt);
        else tvalid = 1'b0;
        nxt++;
      end
    end
    run_acc = acc_cnt - acc_base;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    tvalid  = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    checks++;
    if (txd !== 1'b0) begin
      failures++;
      $display("FAIL reset_txd got=%b expected=0", txd);
    end
    checks++;
    if (tready !== 1'b0) begin
      failures++;
      $display("FAIL reset_tready got=%b expected=0", tready);
    end
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    checks++;
    if (tready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_tready got=%b expected=1", tready);
    end
    checks++;
    if (txd !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_txd got=%b expected=0", txd);
    end
  endtask

  task automatic test_single_word();
    int nf;
    n_words = 1;
    w_data[0] = 'hCC; w_last[0] = 1; w_per[0] = 100; w_dhi[0] = 75; w_dlo[0] = 25;
    run_frame();
    nf = 0;
    for (int t = 0; t < n_cyc && nf < 4; t++) begin
      checks++;
      if (obs_txd[t] !== exp_txd[t]) begin
        failures++; nf++;
        $display("FAIL single_txd cycle=%0d got=%b expected=%b", t, obs_txd[t], exp_txd[t]);
      end
      checks++;
      if (obs_rdy[t] !== exp_rdy[t]) begin
        failures++; nf++;
        $display("FAIL single_tready cycle=%0d got=%b expected=%b", t, obs_rdy[t], exp_rdy[t]);
      end
    end
    checks++;
    if (run_acc !== 1) begin
      failures++;
      $display("FAIL single_accepts got=%0d expected=1", run_acc);
    end
  endtask

  task automatic test_back_to_back();
    int nf;
    n_words = 2;
    w_data[0] = 'hFF; w_last[0] = 0; w_per[0] = 10; w_dhi[0] = 7; w_dlo[0] = 3;
    w_data[1] = 'h00; w_last[1] = 1; w_per[1] = 10; w_dhi[1] = 7; w_dlo[1] = 3;
    run_frame();
    nf = 0;
    for (int t = 0; t < n_cyc && nf < 4; t++) begin
      checks++;
      if (obs_txd[t] !== exp_txd[t]) begin
        failures++; nf++;
        $display("FAIL b2b_txd cycle=%0d got=%b expected=%b", t, obs_txd[t], exp_txd[t]);
      end
      checks++;
      if (obs_rdy[t] !== exp_rdy[t]) begin
        failures++; nf++;
        $display("FAIL b2b_tready cycle=%0d got=%b expected=%b", t, obs_rdy[t], exp_rdy[t]);
      end
    end
    checks++;
    if (run_acc !== 2) begin
      failures++;
      $display("FAIL b2b_accepts got=%0d expected=2", run_acc);
    end
  endtask

  task automatic test_duty_extremes();
    int nf;
    for (int v = 0; v < 2; v++) begin
      n_words = 1;
      w_data[0] = 'hAA; w_last[0] = 1; w_per[0] = 10;
      w_dhi[0] = (v == 0) ? 10 : 12; w_dlo[0] = 0;
      run_frame();
      nf = 0;
      for (int t = 0; t < n_cyc && nf < 4; t++) begin
        checks++;
        if (obs_txd[t] !== exp_txd[t]) begin
          failures++; nf++;
          $display("FAIL duty_txd dhi=%0d cycle=%0d got=%b expected=%b", w_dhi[0], t, obs_txd[t], exp_txd[t]);
        end
        checks++;
        if (obs_rdy[t] !== exp_rdy[t]) begin
          failures++; nf++;
          $display("FAIL duty_tready dhi=%0d cycle=%0d got=%b expected=%b", w_dhi[0], t, obs_rdy[t], exp_rdy[t]);
        end
      end
    end
  endtask

  task automatic test_config_change();
    int nf;
    n_words = 2;
    w_data[0] = 'hA5; w_last[0] = 0; w_per[0] = 20; w_dhi[0] = 15; w_dlo[0] = 5;
    w_data[1] = 'h3C; w_last[1] = 1; w_per[1] = 5;  w_dhi[1] = 4;  w_dlo[1] = 1;
    run_frame();
    nf = 0;
    for (int t = 0; t < n_cyc && nf < 4; t++) begin
      checks++;
      if (obs_txd[t] !== exp_txd[t]) begin
        failures++; nf++;
        $display("FAIL cfgchg_txd cycle=%0d got=%b expected=%b", t, obs_txd[t], exp_txd[t]);
      end
      checks++;
      if (obs_rdy[t] !== exp_rdy[t]) begin
        failures++; nf++;
        $display("FAIL cfgchg_tready cycle=%0d got=%b expected=%b", t, obs_rdy[t], exp_rdy[t]);
      end
    end
  endtask

  task automatic test_reset_mid_word();
    int nf;
    tdata = 'hFF; tlast = 1'b1; period = 10; duty_hi = 7; duty_lo = 3;
    tvalid = 1'b1;
    @(posedge aclk);
    #1;
    tvalid = 1'b0;
    // Edge 32 is position 1 of slot 3, a 1 bit with duty 7, so txd is high.
    repeat (32) @(posedge aclk);
    #1;
    checks++;
    if (txd !== 1'b1) begin
      failures++;
      $display("FAIL midrst_before_txd got=%b expected=1", txd);
    end
    #2;
    aresetn = 1'b0;
    #1;
    checks++;
    if (txd !== 1'b0) begin
      failures++;
      $display("FAIL midrst_txd got=%b expected=0", txd);
    end
    checks++;
    if (tready !== 1'b0) begin
      failures++;
      $display("FAIL midrst_tready got=%b expected=0", tready);
    end
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    checks++;
    if (tready !== 1'b1) begin
      failures++;
      $display("FAIL midrst_release_tready got=%b expected=1", tready);
    end
    n_words = 1;
    w_data[0] = 'h5A; w_last[0] = 1; w_per[0] = 6; w_dhi[0] = 4; w_dlo[0] = 2;
    run_frame();
    nf = 0;
    for (int t = 0; t < n_cyc && nf < 4; t++) begin
      checks++;
      if (obs_txd[t] !== exp_txd[t]) begin
        failures++; nf++;
        $display("FAIL midrst_next_txd cycle=%0d got=%b expected=%b", t, obs_txd[t], exp_txd[t]);
      end
      checks++;
      if (obs_rdy[t] !== exp_rdy[t]) begin
        failures++; nf++;
        $display("FAIL midrst_next_tready cycle=%0d got=%b expected=%b", t, obs_rdy[t], exp_rdy[t]);
      end
    end
  endtask

  task automatic test_zero_period();
    int nf;
    n_words = 1;
    w_data[0] = 'h80; w_last[0] = 1; w_per[0] = 0; w_dhi[0] = 5; w_dlo[0] = 0;
    run_frame();
    nf = 0;
    for (int t = 0; t < n_cyc && nf < 4; t++) begin
      checks++;
      if (obs_txd[t] !== exp_txd[t]) begin
        failures++; nf++;
        $display("FAIL zeroper_txd cycle=%0d got=%b expected=%b", t, obs_txd[t], exp_txd[t]);
      end
      checks++;
      if (obs_rdy[t] !== exp_rdy[t]) begin
        failures++; nf++;
        $display("FAIL zeroper_tready cycle=%0d got=%b expected=%b", t, obs_rdy[t], exp_rdy[t]);
      end
    end
  endtask

  task automatic test_random();
    int nf;
    for (int r = 0; r < 6; r++) begin
      n_words = int'($urandom_range(1, 4));
      for (int i = 0; i < n_words; i++) begin
        w_data[i] = int'($urandom_range(0, 255));
        w_last[i] = int'($urandom_range(0, 1));
        w_per[i]  = int'($urandom_range(0, 12));
        w_dhi[i]  = int'($urandom_range(0, 14));
        w_dlo[i]  = int'($urandom_range(0, 14));
      end
      run_frame();
      nf = 0;
      for (int t = 0; t < n_cyc && nf < 4; t++) begin
        checks++;
        if (obs_txd[t] !== exp_txd[t]) begin
          failures++; nf++;
          $display("FAIL rand_txd run=%0d cycle=%0d got=%b expected=%b", r, t, obs_txd[t], exp_txd[t]);
        end
        checks++;
        if (obs_rdy[t] !== exp_rdy[t]) begin
          failures++; nf++;
          $display("FAIL rand_tready run=%0d cycle=%0d got=%b expected=%b", r, t, obs_rdy[t], exp_rdy[t]);
        end
      end
      checks++;
      if (run_acc !== n_words) begin
        failures++;
        $display("FAIL rand_accepts run=%0d got=%0d expected=%0d", r, run_acc, n_words);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_duty_extremes();
    test_config_change();
    test_reset_mid_word();
    test_zero_period();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pw_bit_cell.md
# pw_bit_cell

Pulse-width bit encoder. It accepts data words on an AXI4-Stream slave and serializes each word MSB-first onto a single output line `txd`. Every bit occupies one fixed-length slot of `period` clocks; the line is high for `duty_hi` clocks for a 1 and `duty_lo` clocks for a 0, then low for the rest of the slot. It sits at the edge of the digital I/O fabric, between a stream source and a one-wire pulse-width-coded pin.

## Interface
- `COUNTER_WIDTH`, default 32: width of the internal slot counter.
- `DATA_AXIS_DATA_WIDTH`, default 8: bits per stream word, equal to the number of slots per word.
- `CFG_AXIS_DATA_WIDTH`, default `COUNTER_WIDTH*2`: width of the configuration inputs.

Ports:
- `aclk` in 1: the single clock. All logic is on the rising edge.
- `aresetn` in 1: asynchronous, active-low reset.
- `txd` out 1: encoded serial output, driven from a register.
- `data_s_axis_tdata` in `DATA_AXIS_DATA_WIDTH`: word to transmit.
- `data_s_axis_tlast` in 1: marks the final word of a frame.
- `data_s_axis_tvalid` in 1: source has a word.
- `data_s_axis_tready` out 1: block can accept a word. Registered.
- `period` in `CFG_AXIS_DATA_WIDTH`: slot length in clocks.
- `duty_hi` in `CFG_AXIS_DATA_WIDTH`: high time for a 1 bit.
- `duty_lo` in `CFG_AXIS_DATA_WIDTH`: high time for a 0 bit.

## Operation
- **Configuration width:** only the low `COUNTER_WIDTH` bits of `period`, `duty_hi` and `duty_lo` are used. They are zero-extended when `CFG_AXIS_DATA_WIDTH` is smaller than `COUNTER_WIDTH`.
- **Configuration capture:** `period`, `duty_hi` and `duty_lo` are captured on every accepted beat. Changes mid-word have no effect until the next acceptance.
- **Zero period:** an effective period of 0 is treated as 1.
- **States:**
  - IDLE: `tready`=1, `txd`=0.
  - BIT: shifting out a word.
  - GAP: inter-frame gap.
- **Acceptance:** a beat is accepted when `tvalid`=1 and `tready`=1 on a rising edge. The block latches tdata, tlast and the configuration, sets bit index to `DATA_AXIS_DATA_WIDTH-1` and the counter to 0, and enters BIT.
- **BIT slot shape:** within a slot, counter c runs 0..P-1.
  - `txd`=1 while c < D, where D is `duty_hi` if the current bit is 1, else `duty_lo`.
  - `txd`=0 otherwise.
  - D ≥ P gives a slot that is high for all of it; D=0 gives a slot that is low for all of it.
- **End of a slot, more bits remaining:** decrement the bit index and reset c to 0.
- **End of the last slot, latched tlast=1:** enter GAP for P clocks with `txd`=0, then go to IDLE.
- **End of the last slot, latched tlast=0:** `tready` is 1 during that final cycle.
  - If `tvalid`=1 there, the next word is accepted and its first slot follows with no gap.
  - Otherwise go to IDLE.
- **tready:** high only in IDLE and in the last cycle of the last slot of a non-tlast word. Low in all other cycles.
- **Reset:** asserting `aresetn` at any time, including mid-word, immediately forces:
  - `txd`=0 and `tready`=0;
  - state IDLE, counter 0, bit index 0.

  After deassertion, `tready` rises on the first clock edge. The aborted word is discarded.

## Timing
- **Slot placement:** for acceptance at edge E0, slot k (k=0 is the MSB) drives `txd` over edges E0+1+k·P through E0+(k+1)·P.
- **First output:** `txd` changes on the edge after acceptance.
- **Word length:** one word occupies exactly `DATA_AXIS_DATA_WIDTH`·P clocks.
- **Frame end:** a tlast word adds P gap clocks before `tready` returns.
- **Back-to-back:** the acceptance edge of the next word is the final edge of the current word. There are no idle cycles between slots.
- **Counter wrap:** the counter never wraps. It is reset at each slot boundary, and P ≤ 2^`COUNTER_WIDTH`−1.

## Test plan
- **Single word:** reset for 2 cycles, then tdata=0xCC, tlast=1, tvalid=1, period=100, duty_hi=75, duty_lo=25, with `COUNTER_WIDTH`=8 and both data widths 8.
  - Exactly one acceptance.
  - `txd` pattern H75/L25 ×2, H25/L75 ×2, H75/L25 ×2, H25/L75 ×2 (800 clocks), then 100 low clocks.
  - `tready` returns 1 only afterwards.
- **Back-to-back:** 0xFF (tlast=0) then 0x00 (tlast=1) with tvalid held, period=10, duty_hi=7, duty_lo=3.
  - 8 slots of 7H/3L immediately followed by 8 slots of 3H/7L.
  - No idle cycle between the words; second acceptance on the final edge of the first word.
- **Duty extremes:** duty_hi=period=10, duty_lo=0, data=0xAA.
  - Alternating solid-high and solid-low 10-clock slots.
  - duty_hi=12 gives the same result, since it is clamped by the slot.
- **Config change mid-word:** change period from 20 to 5 during a word.
  - Current word keeps 20-clock slots.
  - The next accepted word uses 5-clock slots.
- **Reset mid-word:** assert `aresetn`=0 at slot 3.
  - `txd` and `tready` go to 0 immediately.
  - After release, `tready`=1 and the next word starts cleanly from its MSB.
- **Zero period:** period=0 with data=0x80.
  - Each slot is 1 clock; the word lasts 8 clocks.
